// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared constants, bank selectors and FSM states for the SHA-256 HK fetch path
//
// Purpose: common definitions imported by sha256_hk_fetch.
//   WORD_W   : width of every H/K word and of the HK read bus
//   H_WORDS  : number of initial hash words (H0..H7)
//   K_WORDS  : number of round constants (K0..K63)
//   HSEL/KSEL: HK memory bank selector encodings
//   state_e  : fetch controller states
package sha256_pkg;

  localparam int WORD_W  = 32;
  localparam int H_WORDS = 8;
  localparam int K_WORDS = 64;
  localparam int H_AW    = 3;
  localparam int K_AW    = 6;

  localparam logic [H_AW-1:0] H_LAST_IDX = 3'd7;
  localparam logic [K_AW-1:0] K_LAST_IDX = 6'd63;

  localparam logic HSEL = 1'b0;
  localparam logic KSEL = 1'b1;

  typedef enum logic [2:0] {
    INIT,
    WAIT_RDY,
    READY,
    LOAD_H,
    FETCH_K,
    PRESENT_K
  } state_e;

endpackage

// File: rtl/sha256_hk_fetch.sv
// rtl/sha256_hk_fetch.sv - HK memory sequencer: ROM copy trigger, initial-H load and K round-constant stream
//
// Purpose: brings the HK memory up (one COPY_ROM pulse if it is not ready yet),
// then per block optionally loads H0..H7 into a 256-bit register and streams
// K0..K63 to the round engine, one word every two clocks.
//
// Ports:
//   CLK, RST        : clock and synchronous active-high reset
//   HK_RDY          : sticky ready flag from HK memory
//   HK_DR           : HK memory read data (combinational w.r.t. the address)
//   COPY_ROM        : copy request to HK memory
//   HK_SELECTOR     : 0 = H bank, 1 = K bank
//   H_ADDR, K_ADDR  : word indices into the H and K banks
//   START, RELOAD_H : block start (READY only) and initial-H reload request
//   H_OUT, H_VALID  : initial hash words (H0 in the top word) and their valid flag
//   K_OUT, K_VALID, K_READY, K_LAST : round-constant stream
//   BUSY, DONE      : not-in-READY indicator and end-of-stream pulse
module sha256_hk_fetch
  import sha256_pkg::*;
(
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        HK_RDY,
  input  logic [WORD_W-1:0]           HK_DR,
  output logic                        COPY_ROM,
  output logic                        HK_SELECTOR,
  output logic [H_AW-1:0]             H_ADDR,
  output logic [K_AW-1:0]             K_ADDR,
  input  logic                        START,
  input  logic                        RELOAD_H,
  output logic [H_WORDS*WORD_W-1:0]   H_OUT,
  output logic                        H_VALID,
  output logic [WORD_W-1:0]           K_OUT,
  output logic                        K_VALID,
  input  logic                        K_READY,
  output logic                        K_LAST,
  output logic                        BUSY,
  output logic                        DONE
);

  state_e                      state_q, state_d;
  logic [H_AW-1:0]             h_idx_q, h_idx_d;
  logic [K_AW-1:0]             t_q, t_d;
  logic [H_WORDS*WORD_W-1:0]   h_out_q, h_out_d;
  logic                        h_valid_q, h_valid_d;
  logic [WORD_W-1:0]           k_out_q, k_out_d;
  logic                        k_last_q, k_last_d;
  logic                        done_q, done_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= INIT;
      h_idx_q   <= '0;
      t_q       <= '0;
      h_out_q   <= '0;
      h_valid_q <= 1'b0;
      k_out_q   <= '0;
      k_last_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_idx_q   <= h_idx_d;
      t_q       <= t_d;
      h_out_q   <= h_out_d;
      h_valid_q <= h_valid_d;
      k_out_q   <= k_out_d;
      k_last_q  <= k_last_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    h_idx_d   = h_idx_q;
    t_d       = t_q;
    h_out_d   = h_out_q;
    h_valid_d = h_valid_q;
    k_out_d   = k_out_q;
    k_last_d  = k_last_q;
    done_d    = 1'b0;

    // HK_RDY dropping while busy is an upstream fault and deliberately not
    // watched outside INIT/WAIT_RDY.
    case (state_q)
      INIT: begin
        state_d = HK_RDY ? READY : WAIT_RDY;
      end
      WAIT_RDY: begin
        if (HK_RDY) state_d = READY;
      end
      READY: begin
        if (START) begin
          t_d = '0;
          if (RELOAD_H) begin
            state_d   = LOAD_H;
            h_idx_d   = '0;
            h_valid_d = 1'b0;
          end else begin
            state_d = FETCH_K;
          end
        end
      end
      LOAD_H: begin
        // Word i lands in H_OUT with H0 in the most significant word.
        for (int i = 0; i < H_WORDS; i++) begin
          if (h_idx_q == 3'(i)) h_out_d[(H_WORDS-1-i)*WORD_W +: WORD_W] = HK_DR;
        end
        if (h_idx_q == H_LAST_IDX) begin
          h_valid_d = 1'b1;
          t_d       = '0;
          state_d   = FETCH_K;
        end else begin
          h_idx_d = h_idx_q + 3'd1;
        end
      end
      FETCH_K: begin
        k_out_d  = HK_DR;
        k_last_d = (t_q == K_LAST_IDX);
        state_d  = PRESENT_K;
      end
      PRESENT_K: begin
        if (K_READY) begin
          if (t_q == K_LAST_IDX) begin
            k_last_d = 1'b0;
            done_d   = 1'b1;
            t_d      = '0;
            state_d  = READY;
          end else begin
            t_d     = t_q + 6'd1;
            state_d = FETCH_K;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Address/selector lines are decoded from the state so the memory sees the
  // new address in the same cycle whose end captures HK_DR.
  always_comb begin
    COPY_ROM    = 1'b0;
    HK_SELECTOR = HSEL;
    H_ADDR      = '0;
    K_ADDR      = '0;
    K_VALID     = 1'b0;
    BUSY        = (state_q != READY);
    // Gated by RST so a held reset never issues a copy request.
    if (state_q == INIT && !HK_RDY && !RST) COPY_ROM = 1'b1;
    if (state_q == LOAD_H) H_ADDR = h_idx_q;
    if (state_q == FETCH_K || state_q == PRESENT_K) begin
      HK_SELECTOR = KSEL;
      K_ADDR      = t_q;
    end
    if (state_q == PRESENT_K) K_VALID = 1'b1;
  end

  assign H_OUT   = h_out_q;
  assign H_VALID = h_valid_q;
  assign K_OUT   = k_out_q;
  assign K_LAST  = k_last_q;
  assign DONE    = done_q;

endmodule
